// File: rtl/alu_op_decoder_if.sv
// Handshake bundle between fetch, the ALU op decoder and issue.
// The decoder takes the slave view; the fetch/issue side takes master.
interface alu_op_decoder_if #(
  parameter int XLEN      = 32,
  parameter int OP_W      = 17,
  parameter int ILL_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [OP_W-1:0]      out_op;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [4:0]           out_rd;
  logic [XLEN-1:0]      out_imm;
  logic                 out_use_imm;
  logic                 out_illegal;
  logic [ILL_CNT_W-1:0] ill_count;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_op,
    input  out_rs1, out_rs2, out_rd, out_imm,
    input  out_use_imm, out_illegal, ill_count
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_op,
    output out_rs1, out_rs2, out_rd, out_imm,
    output out_use_imm, out_illegal, ill_count
  );
endinterface

// File: rtl/alu_op_decoder.sv
// RV32 decode stage: instruction word -> ALU op vector and operands.
// Registered output plus one-entry skid buffer for full throughput.
module alu_op_decoder #(
  parameter int XLEN      = 32,
  parameter int OP_W      = 17,
  parameter int ILL_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_decoder_if.slave    bus
);

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [OP_W-1:0] OP_ADD = 17'h00033;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            illegal;
  } dec_t;

  dec_t                 r_out;
  dec_t                 r_skid;
  logic                 r_out_v;
  logic                 r_skid_v;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  dec_t       w_dec;
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [6:0] w_f7i;
  logic       w_r_ok;
  logic       w_i_ok;
  logic       w_in_fire;
  logic       w_load;

  assign w_opc = bus.in_instr[6:0];
  assign w_f3  = bus.in_instr[14:12];
  assign w_f7  = bus.in_instr[31:25];

  assign w_f7i = (w_f3 == 3'b101) ? w_f7 : 7'b0;

  assign w_r_ok = (w_f7 == 7'b0) ||
                  ((w_f7 == F7_ALT) &&
                   (w_f3 == 3'b000 || w_f3 == 3'b101));

  always_comb begin
    w_i_ok = 1'b1;
    if (w_f3 == 3'b001)
      w_i_ok = (w_f7 == 7'b0);
    else if (w_f3 == 3'b101)
      w_i_ok = (w_f7 == 7'b0) || (w_f7 == F7_ALT);
  end

  // Unsupported words fall through as an ADD to x0.
  always_comb begin
    w_dec         = '0;
    w_dec.op      = OP_ADD;
    w_dec.illegal = 1'b1;
    unique case (1'b1)
      (w_opc == OPC_R): begin
        if (w_r_ok) begin
          w_dec.op      = {w_f7, w_f3, OPC_R};
          w_dec.rs1     = bus.in_instr[19:15];
          w_dec.rs2     = bus.in_instr[24:20];
          w_dec.rd      = bus.in_instr[11:7];
          w_dec.illegal = 1'b0;
        end
      end
      (w_opc == OPC_I): begin
        if (w_i_ok) begin
          w_dec.op      = {w_f7i, w_f3, OPC_R};
          w_dec.rs1     = bus.in_instr[19:15];
          w_dec.rd      = bus.in_instr[11:7];
          w_dec.imm     = {{(XLEN-12){bus.in_instr[31]}},
                           bus.in_instr[31:20]};
          w_dec.use_imm = 1'b1;
          w_dec.illegal = 1'b0;
        end
      end
      (w_opc == OPC_LUI): begin
        w_dec.rd      = bus.in_instr[11:7];
        w_dec.imm     = {bus.in_instr[31:12], 12'b0};
        w_dec.use_imm = 1'b1;
        w_dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.in_ready = rst_n & ~r_skid_v;
  assign w_in_fire    = bus.in_valid & bus.in_ready;
  assign w_load       = ~r_out_v | bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_skid    <= '0;
      r_out_v   <= 1'b0;
      r_skid_v  <= 1'b0;
      r_ill_cnt <= '0;
    end else begin
      if (w_load) begin
        if (r_skid_v) begin
          r_out    <= r_skid;
          r_out_v  <= 1'b1;
          r_skid_v <= 1'b0;
        end else if (w_in_fire) begin
          r_out   <= w_dec;
          r_out_v <= 1'b1;
        end else begin
          r_out_v <= 1'b0;
        end
      end else if (w_in_fire) begin
        r_skid   <= w_dec;
        r_skid_v <= 1'b1;
      end
      if (w_in_fire && w_dec.illegal && (r_ill_cnt != '1))
        r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end

  assign bus.out_valid   = r_out_v;
  assign bus.out_op      = r_out.op;
  assign bus.out_rs1     = r_out.rs1;
  assign bus.out_rs2     = r_out.rs2;
  assign bus.out_rd      = r_out.rd;
  assign bus.out_imm     = r_out.imm;
  assign bus.out_use_imm = r_out.use_imm;
  assign bus.out_illegal = r_out.illegal;
  assign bus.ill_count   = r_ill_cnt;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed-vector bench for the ALU op decoder stage.
// Each task drives one scenario and checks outputs after the edge.
module tb_alu_op_decoder;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_op_decoder_if #(.XLEN(32), .OP_W(17), .ILL_CNT_W(8)) b ();

  alu_op_decoder #(.XLEN(32), .OP_W(17), .ILL_CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [31:0] w);
    b.in_valid = 1'b1;
    b.in_instr = w;
    tick();
    b.in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    b.in_valid  = 1'b0;
    b.in_instr  = 32'h0;
    b.out_ready = 1'b1;
    repeat (2) tick();
    n_vec++; if (b.out_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_out_valid act=%b exp=0", b.out_valid); end
    n_vec++; if (b.in_ready !== 1'b0) begin n_err++;
      $display("FAIL rst_in_ready act=%b exp=0", b.in_ready); end
    n_vec++; if (b.ill_count !== 8'd0) begin n_err++;
      $display("FAIL rst_ill_count act=%0d exp=0", b.ill_count); end
    n_vec++; if (b.out_op !== 17'h0) begin n_err++;
      $display("FAIL rst_out_op act=%h exp=0", b.out_op); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (b.in_ready !== 1'b1) begin n_err++;
      $display("FAIL rel_in_ready act=%b exp=1", b.in_ready); end
    tick();
    n_vec++; if (b.out_valid !== 1'b0) begin n_err++;
      $display("FAIL rel_out_valid act=%b exp=0", b.out_valid); end
  endtask

  task automatic test_rtype();
    send_one(32'h002081B3);
    n_vec++; if (b.out_valid !== 1'b1) begin n_err++;
      $display("FAIL add_valid act=%b exp=1", b.out_valid); end
    n_vec++; if (b.out_op !== 17'h00033) begin n_err++;
      $display("FAIL add_op act=%h exp=00033", b.out_op); end
    n_vec++; if ({b.out_rs1, b.out_rs2, b.out_rd} !== {5'd1, 5'd2, 5'd3})
      begin n_err++;
      $display("FAIL add_regs act=%0d,%0d,%0d exp=1,2,3",
               b.out_rs1, b.out_rs2, b.out_rd); end
    n_vec++; if ({b.out_use_imm, b.out_illegal} !== 2'b00
                 || b.out_imm !== 32'h0) begin n_err++;
      $display("FAIL add_imm act=%b%b/%h exp=00/0",
               b.out_use_imm, b.out_illegal, b.out_imm); end
    send_one(32'h007322B3);
    n_vec++; if (b.out_op !== 17'h00133) begin n_err++;
      $display("FAIL slt_op act=%h exp=00133", b.out_op); end
    n_vec++; if ({b.out_rs1, b.out_rs2, b.out_rd} !== {5'd6, 5'd7, 5'd5})
      begin n_err++;
      $display("FAIL slt_regs act=%0d,%0d,%0d exp=6,7,5",
               b.out_rs1, b.out_rs2, b.out_rd); end
    send_one(32'h40208033);
    n_vec++; if (b.out_op !== 17'h08033) begin n_err++;
      $display("FAIL sub_op act=%h exp=08033", b.out_op); end
    n_vec++; if (b.out_illegal !== 1'b0) begin n_err++;
      $display("FAIL sub_illegal act=%b exp=0", b.out_illegal); end
  endtask

  task automatic test_itype();
    send_one(32'hFFF00093);
    n_vec++; if (b.out_op !== 17'h00033) begin n_err++;
      $display("FAIL addi_op act=%h exp=00033", b.out_op); end
    n_vec++; if (b.out_imm !== 32'hFFFFFFFF) begin n_err++;
      $display("FAIL addi_imm act=%h exp=ffffffff", b.out_imm); end
    n_vec++; if ({b.out_use_imm, b.out_rs2, b.out_rd} !== {1'b1, 5'd0, 5'd1})
      begin n_err++;
      $display("FAIL addi_fields act=%b,%0d,%0d exp=1,0,1",
               b.out_use_imm, b.out_rs2, b.out_rd); end
    send_one(32'h4030D093);
    n_vec++; if (b.out_op !== 17'h082B3) begin n_err++;
      $display("FAIL srai_op act=%h exp=082b3", b.out_op); end
    n_vec++; if (b.out_imm !== 32'h00000403) begin n_err++;
      $display("FAIL srai_imm act=%h exp=00000403", b.out_imm); end
    send_one(32'h02009093);
    n_vec++; if ({b.out_illegal, b.out_op, b.out_rd} !=
                 {1'b1, 17'h00033, 5'd0}) begin n_err++;
      $display("FAIL slli_bad act=%b/%h/%0d exp=1/00033/0",
               b.out_illegal, b.out_op, b.out_rd); end
  endtask

  task automatic test_lui();
    send_one(32'h12345237);
    n_vec++; if (b.out_imm !== 32'h12345000) begin n_err++;
      $display("FAIL lui_imm act=%h exp=12345000", b.out_imm); end
    n_vec++; if ({b.out_rs1, b.out_rs2, b.out_rd} !== {5'd0, 5'd0, 5'd4})
      begin n_err++;
      $display("FAIL lui_regs act=%0d,%0d,%0d exp=0,0,4",
               b.out_rs1, b.out_rs2, b.out_rd); end
    n_vec++; if ({b.out_op, b.out_use_imm} !== {17'h00033, 1'b1})
      begin n_err++;
      $display("FAIL lui_op act=%h/%b exp=00033/1",
               b.out_op, b.out_use_imm); end
  endtask

  task automatic test_illegal();
    apply_reset();
    send_one(32'h00000000);
    n_vec++; if ({b.out_illegal, b.out_op, b.out_rd} !==
                 {1'b1, 17'h00033, 5'd0}) begin n_err++;
      $display("FAIL ill0_bundle act=%b/%h/%0d exp=1/00033/0",
               b.out_illegal, b.out_op, b.out_rd); end
    n_vec++; if (b.ill_count !== 8'd1) begin n_err++;
      $display("FAIL ill0_count act=%0d exp=1", b.ill_count); end
    send_one(32'h02208033);
    n_vec++; if ({b.out_illegal, b.out_imm, b.out_use_imm} !==
                 {1'b1, 32'h0, 1'b0}) begin n_err++;
      $display("FAIL ill1_bundle act=%b/%h/%b exp=1/0/0",
               b.out_illegal, b.out_imm, b.out_use_imm); end
    n_vec++; if ({b.out_rs1, b.out_rs2} !== 10'd0) begin n_err++;
      $display("FAIL ill1_regs act=%0d,%0d exp=0,0",
               b.out_rs1, b.out_rs2); end
    n_vec++; if (b.ill_count !== 8'd2) begin n_err++;
      $display("FAIL ill1_count act=%0d exp=2", b.ill_count); end
    b.in_valid = 1'b1;
    b.in_instr = 32'hFFFFFFFF;
    repeat (252) @(posedge clk);
    #1;
    n_vec++; if (b.ill_count !== 8'd254) begin n_err++;
      $display("FAIL ill_254 act=%0d exp=254", b.ill_count); end
    repeat (46) @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    n_vec++; if (b.ill_count !== 8'd255) begin n_err++;
      $display("FAIL ill_sat act=%0d exp=255", b.ill_count); end
  endtask

  task automatic test_backpressure();
    tick();
    b.out_ready = 1'b0;
    b.in_valid  = 1'b1;
    b.in_instr  = 32'h002081B3;
    tick();
    n_vec++; if ({b.out_valid, b.out_rd, b.in_ready} !== {1'b1, 5'd3, 1'b1})
      begin n_err++;
      $display("FAIL bp_w1 act=%b/%0d/%b exp=1/3/1",
               b.out_valid, b.out_rd, b.in_ready); end
    b.in_instr = 32'h007322B3;
    tick();
    n_vec++; if (b.in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_full act=%b exp=0", b.in_ready); end
    b.in_instr = 32'hFFF00093;
    repeat (2) tick();
    n_vec++; if ({b.out_valid, b.out_rd, b.out_op, b.in_ready} !==
                 {1'b1, 5'd3, 17'h00033, 1'b0}) begin n_err++;
      $display("FAIL bp_stable act=%b/%0d/%h/%b exp=1/3/00033/0",
               b.out_valid, b.out_rd, b.out_op, b.in_ready); end
    b.out_ready = 1'b1;
    tick();
    n_vec++; if ({b.out_valid, b.out_rd, b.out_op} !==
                 {1'b1, 5'd5, 17'h00133}) begin n_err++;
      $display("FAIL bp_w2 act=%b/%0d/%h exp=1/5/00133",
               b.out_valid, b.out_rd, b.out_op); end
    n_vec++; if (b.in_ready !== 1'b1) begin n_err++;
      $display("FAIL bp_drain_rdy act=%b exp=1", b.in_ready); end
    tick();
    b.in_valid = 1'b0;
    n_vec++; if ({b.out_valid, b.out_rd, b.out_imm} !==
                 {1'b1, 5'd1, 32'hFFFFFFFF}) begin n_err++;
      $display("FAIL bp_w3 act=%b/%0d/%h exp=1/1/ffffffff",
               b.out_valid, b.out_rd, b.out_imm); end
    tick();
    n_vec++; if (b.out_valid !== 1'b0) begin n_err++;
      $display("FAIL bp_empty act=%b exp=0", b.out_valid); end
  endtask

  task automatic test_reset_mid();
    b.out_ready = 1'b0;
    b.in_valid  = 1'b1;
    b.in_instr  = 32'h002081B3;
    repeat (2) tick();
    b.in_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    n_vec++; if (b.in_ready !== 1'b0) begin n_err++;
      $display("FAIL mid_rdy act=%b exp=0", b.in_ready); end
    tick();
    n_vec++; if (b.out_valid !== 1'b0) begin n_err++;
      $display("FAIL mid_valid act=%b exp=0", b.out_valid); end
    rst_n       = 1'b1;
    b.out_ready = 1'b1;
    tick();
    n_vec++; if ({b.out_valid, b.in_ready} !== 2'b01) begin n_err++;
      $display("FAIL mid_after act=%b%b exp=01",
               b.out_valid, b.in_ready); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_rtype();
    test_itype();
    test_lui();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
